// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock flexible FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_t;

  // The count has to hold the value DEPTH itself, not only DEPTH-1.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sync_flex_if.sv
// Producer/consumer signal bundle for fifo_sync_flex; the master side is the FIFO user.
interface fifo_sync_flex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
);

  localparam int CW = fifo_pkg::count_width(DEPTH);

  logic                  flush;
  logic                  clear_err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clear_err, wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clear_err, wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH wrapping pointer with increment enable and synchronous clear.
module fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with arbitrary depth, STD or FWFT read mode, threshold flags,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         DEPTH      = 1024,
  parameter fifo_mode_t MODE       = FIFO_STD,
  parameter int         AF_LEVEL   = DEPTH - 1,
  parameter int         AE_LEVEL   = 1
) (
  input logic             clock,
  input logic             reset,
  fifo_sync_flex_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] xz_to_zero(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = (v[i] === 1'b1);
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  overflow_q;
  logic                  overflow_d;
  logic                  underflow_q;
  logic                  underflow_d;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] head;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Flush swallows the cycle's requests, so neither side is accepted.
  assign wr_acc = bus.wr_en && !full  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty && !bus.flush;
  assign head   = xz_to_zero(mem_q[rd_ptr]);

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_ptr] <= bus.din;
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  // A new error event outranks clear_err in the same cycle.
  always_comb begin
    overflow_d  = bus.clear_err ? 1'b0 : overflow_q;
    underflow_d = bus.clear_err ? 1'b0 : underflow_q;
    if (!bus.flush && bus.wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (!bus.flush && bus.rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) begin
        dout_d = head;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign bus.dout = dout_q;
  end else begin : g_fwft
    assign bus.dout = empty ? '0 : head;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
